// File: rtl/lockin_reset_sequencer.sv
// lockin_reset_sequencer
//
// Sequences reset for the lock-in datapath stages under software control.
// All stages are held in reset for a programmable number of cycles. They are
// then released one at a time in index order, and each stage's ready is
// awaited before the next stage is released. The same sequence runs after
// system reset.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   address      Avalon-MM register select (0 CTRL, 1 STATUS, 2 HOLD, 3 COUNT)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     read data, combinational from address
//   stage_ready  per-stage operational flags
//   stage_rst    per-stage active-high reset, registered
//   out_port     legacy software-reset line, equal to busy
//
// Optional feature: define LOCKIN_RST_TIMEOUT_EN to enable the per-stage
// ready timeout (TIMEOUT_CYCLES) and the sticky timeout flag in STATUS.
module lockin_reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter logic [15:0] HOLD_DEFAULT   = 16'd16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  out_port
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           hold_cnt_q, hold_cnt_d;
    logic [15:0]           hold_reg_q, hold_reg_d;
    logic                  hold_bit_q, hold_bit_d;
    logic [2:0]            idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    // Set on entry to RELEASE(i) so ready is not sampled on the entry cycle.
    logic                  rel_first_q, rel_first_d;

    logic                  tmo_flag;
    logic [2:0]            tmo_idx;
    logic [7:0]            rdy_ext;
    logic                  busy;
    logic                  wr, wr_ctrl, wr_status, wr_hold;
    logic                  advance;
    logic                  unused_wdata;

`ifdef LOCKIN_RST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [2:0]    tmo_idx_q, tmo_idx_d;
    assign tmo_flag = tmo_flag_q;
    assign tmo_idx  = tmo_idx_q;
`else
    assign tmo_flag = 1'b0;
    assign tmo_idx  = 3'd0;
`endif

    assign unused_wdata = ^writedata[31:16];

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == 2'd0);
    assign wr_status = wr && (address == 2'd1);
    assign wr_hold   = wr && (address == 2'd2);
    assign busy      = (state_q != ST_IDLE);
    assign out_port  = busy;
    assign stage_rst = stage_rst_q;

    always_comb begin
        rdy_ext = '0;
        rdy_ext[NUM_STAGES-1:0] = stage_ready;
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        hold_reg_d  = hold_reg_q;
        hold_bit_d  = hold_bit_q;
        idx_d       = idx_q;
        count_d     = count_q;
        rel_first_d = rel_first_q;
        stage_rst_d = '0;
        advance     = 1'b0;
`ifdef LOCKIN_RST_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        tmo_idx_d  = tmo_idx_q;
        // Clear first so a timeout raised this cycle overrides it below.
        if (wr_status && writedata[8]) begin
            tmo_flag_d = 1'b0;
        end
`endif

        if (wr_ctrl) begin
            hold_bit_d = writedata[1];
        end
        if (wr_hold) begin
            hold_reg_d = writedata[15:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && writedata[0]) begin
                    state_d    = ST_ASSERT;
                    hold_cnt_d = hold_reg_q;
                    idx_d      = 3'd0;
                end
            end
            ST_ASSERT: begin
                // A count of 0 or 1 is terminal, so HOLD=0 behaves as 1.
                if (hold_cnt_q > 16'd1) begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end else if (!hold_bit_q) begin
                    state_d     = ST_RELEASE;
                    idx_d       = 3'd0;
                    rel_first_d = 1'b1;
`ifdef LOCKIN_RST_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            ST_RELEASE: begin
                rel_first_d = 1'b0;
                if (!rel_first_q && rdy_ext[idx_q]) begin
                    advance = 1'b1;
                end
`ifdef LOCKIN_RST_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (!advance && (tmo_cnt_q == TW'(TIMEOUT_CYCLES))) begin
                    advance    = 1'b1;
                    tmo_flag_d = 1'b1;
                    tmo_idx_d  = idx_q;
                end
`endif
                if (advance) begin
                    if (idx_q == 3'(NUM_STAGES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d       = idx_q + 3'd1;
                        rel_first_d = 1'b1;
`ifdef LOCKIN_RST_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                count_d = count_q + 16'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset outputs follow the next state so they change on the same edge.
        case (state_d)
            ST_ASSERT: stage_rst_d = '1;
            ST_RELEASE: begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    stage_rst_d[k] = (k > 32'(idx_d));
                end
            end
            default: stage_rst_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            hold_cnt_q  <= HOLD_DEFAULT;
            hold_reg_q  <= HOLD_DEFAULT;
            hold_bit_q  <= 1'b0;
            idx_q       <= 3'd0;
            count_q     <= '0;
            stage_rst_q <= '1;
            rel_first_q <= 1'b0;
`ifdef LOCKIN_RST_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
            tmo_idx_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_reg_q  <= hold_reg_d;
            hold_bit_q  <= hold_bit_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            stage_rst_q <= stage_rst_d;
            rel_first_q <= rel_first_d;
`ifdef LOCKIN_RST_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flag_q  <= tmo_flag_d;
            tmo_idx_q   <= tmo_idx_d;
`endif
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = {30'd0, hold_bit_q, busy};
            2'd1: readdata = {8'd0, rdy_ext, 4'd0, tmo_idx, tmo_flag,
                              1'b0, idx_q, 1'b0, state_q};
            2'd2: readdata = {16'd0, hold_reg_q};
            2'd3: readdata = {16'd0, count_q};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lockin_reset_sequencer.sv
module tb_lockin_reset_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  stage_ready;
    logic [3:0]  stage_rst;
    logic        out_port;

    int unsigned n_total;
    int unsigned n_bad;
    logic [31:0] rdv;

    lockin_reset_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_DEFAULT  (16'd16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .stage_ready(stage_ready),
        .stage_rst  (stage_rst),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_idle(input string tag, input int unsigned max_cycles);
        int unsigned n;
        n = 0;
        while (out_port && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, {31'd0, out_port}, 32'd0);
    endtask

    // Timeline from the last reset edge with HOLD=16 and all ready high.
    task automatic post_reset_seq(input logic [15:0] exp_cnt);
        check("rst_hold_start", {28'd0, stage_rst}, 32'hF);
        for (int unsigned i = 1; i < 16; i++) begin
            tick();
            check("rst_hold_f", {28'd0, stage_rst}, 32'hF);
        end
        tick(); check("rel0_a", {28'd0, stage_rst}, 32'hE);
        tick(); check("rel0_b", {28'd0, stage_rst}, 32'hE);
        tick(); check("rel1_a", {28'd0, stage_rst}, 32'hC);
        tick(); check("rel1_b", {28'd0, stage_rst}, 32'hC);
        tick(); check("rel2_a", {28'd0, stage_rst}, 32'h8);
        tick(); check("rel2_b", {28'd0, stage_rst}, 32'h8);
        tick(); check("rel3_a", {28'd0, stage_rst}, 32'h0);
        tick(); check("rel3_busy", {31'd0, out_port}, 32'd1);
        tick();
        bus_rd(2'd1, rdv);
        check("done_state", rdv & 32'h7, 32'd3);
        tick();
        check("idle_busy", {31'd0, out_port}, 32'd0);
        bus_rd(2'd3, rdv);
        check("count_after_seq", rdv, {16'd0, exp_cnt});
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        stage_ready = 4'hF;

        // Power-on reset values
        tick(); tick(); tick();
        check("reset_rst", {28'd0, stage_rst}, 32'hF);
        check("reset_outport", {31'd0, out_port}, 32'd1);
        bus_rd(2'd1, rdv); check("reset_status", rdv, 32'h000F0001);
        bus_rd(2'd2, rdv); check("reset_hold", rdv, 32'd16);
        bus_rd(2'd3, rdv); check("reset_count", rdv, 32'd0);
        bus_rd(2'd0, rdv); check("reset_ctrl", rdv, 32'd1);
        reset = 1'b0;
        post_reset_seq(16'd1);

        // HOLD=5, start, ignored start in RELEASE and in DONE
        bus_wr(2'd2, 32'd5);
        bus_rd(2'd2, rdv); check("hold_rd", rdv, 32'd5);
        bus_wr(2'd0, 32'd1);
        check("h5_assert", {28'd0, stage_rst}, 32'hF);
        for (int unsigned i = 1; i < 5; i++) begin
            tick();
            check("h5_hold_f", {28'd0, stage_rst}, 32'hF);
        end
        tick(); check("h5_rel0", {28'd0, stage_rst}, 32'hE);
        bus_wr(2'd0, 32'd1);
        check("h5_ign_rel", {28'd0, stage_rst}, 32'hE);
        tick(); check("h5_rel1", {28'd0, stage_rst}, 32'hC);
        tick(); tick(); check("h5_rel2", {28'd0, stage_rst}, 32'h8);
        tick(); tick(); check("h5_rel3", {28'd0, stage_rst}, 32'h0);
        tick(); tick();
        bus_rd(2'd1, rdv); check("h5_done", rdv & 32'h7, 32'd3);
        bus_wr(2'd0, 32'd1);
        bus_rd(2'd1, rdv); check("h5_ign_done", rdv & 32'h7, 32'd0);
        bus_rd(2'd3, rdv); check("h5_count", rdv, 32'd2);
        tick();
        check("h5_still_idle", {27'd0, out_port, stage_rst}, 32'd0);

        // Hold bit outside ASSERT only updates the register
        bus_wr(2'd0, 32'd2);
        bus_rd(2'd0, rdv); check("hold_bit_idle", rdv, 32'd2);
        bus_wr(2'd0, 32'd0);
        bus_rd(2'd0, rdv); check("hold_bit_clr", rdv, 32'd0);

        // Start with hold active, stays in ASSERT
        bus_wr(2'd0, 32'd3);
        for (int unsigned i = 0; i < 100; i++) begin
            tick();
            bus_rd(2'd1, rdv);
            check("hold_stay", rdv & 32'h7, 32'd1);
        end
        bus_wr(2'd0, 32'd0);
        bus_rd(2'd1, rdv); check("hold_clr_edge", rdv & 32'h7, 32'd1);
        tick();
        bus_rd(2'd1, rdv); check("hold_clr_rel", rdv & 32'h77, 32'h02);
        check("hold_clr_rst", {28'd0, stage_rst}, 32'hE);
        wait_idle("hold_wait_idle", 40);
        bus_rd(2'd3, rdv); check("hold_count", rdv, 32'd3);

        // Stage 1 ready held low
        stage_ready = 4'b1101;
        bus_wr(2'd0, 32'd1);
        for (int unsigned i = 0; i < 5; i++) tick();
        check("rdy_rel0", {28'd0, stage_rst}, 32'hE);
        tick(); tick();
        check("rdy_rel1", {28'd0, stage_rst}, 32'hC);
`ifdef LOCKIN_RST_TIMEOUT_EN
        for (int unsigned i = 0; i < 1024; i++) tick();
        check("tmo_before", {28'd0, stage_rst}, 32'hC);
        tick();
        check("tmo_rel2", {28'd0, stage_rst}, 32'h8);
        bus_rd(2'd1, rdv); check("tmo_status", rdv, 32'h000D0322);
        bus_wr(2'd1, 32'h100);
        bus_rd(2'd1, rdv); check("tmo_clear", rdv, 32'h000D0222);
        stage_ready = 4'b1110;
`else
        for (int unsigned i = 0; i < 1100; i++) tick();
        check("wait_forever", {28'd0, stage_rst}, 32'hC);
        bus_rd(2'd1, rdv); check("wait_status", rdv, 32'h000D0012);
        bus_wr(2'd1, 32'h100);
        bus_rd(2'd1, rdv); check("wait_clr_ign", rdv, 32'h000D0012);
        stage_ready = 4'b1100;
        tick(); tick(); tick();
        check("rdy0_drop", {28'd0, stage_rst}, 32'hC);
        stage_ready = 4'b1110;
        tick();
        check("rdy1_rel2", {28'd0, stage_rst}, 32'h8);
`endif
        wait_idle("rdy_wait_idle", 40);
        bus_rd(2'd3, rdv); check("rdy_count", rdv, 32'd4);
        stage_ready = 4'hF;

        // Reset in RELEASE(2)
        bus_wr(2'd0, 32'd1);
        for (int unsigned i = 0; i < 9; i++) tick();
        bus_rd(2'd1, rdv); check("mid_rel2", rdv & 32'h77, 32'h22);
        check("mid_rst", {28'd0, stage_rst}, 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_rst", {28'd0, stage_rst}, 32'hF);
        bus_rd(2'd3, rdv); check("mid_reset_count", rdv, 32'd0);
        bus_rd(2'd1, rdv); check("mid_reset_state", rdv & 32'h77, 32'h01);
        post_reset_seq(16'd1);

        // COUNT wrap, HOLD=0 behaves as 1
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        bus_rd(2'd3, rdv); check("wrap_pre", rdv, 32'h0000FFFF);
        bus_wr(2'd2, 32'd0);
        bus_rd(2'd2, rdv); check("hold0_rd", rdv, 32'd0);
        bus_wr(2'd0, 32'd1);
        check("hold0_assert", {28'd0, stage_rst}, 32'hF);
        tick();
        check("hold0_rel0", {28'd0, stage_rst}, 32'hE);
        wait_idle("wrap_wait_idle", 40);
        bus_rd(2'd3, rdv); check("wrap_count", rdv, 32'h00000000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lockin_reset_sequencer.md
# lockin_reset_sequencer

Avalon-MM slave that sequences reset for the lock-in datapath stages (ADC capture, mixer, filter, accumulator) under software control from the Nios processor. Holds every stage in reset for a programmable time, then releases stages one at a time in index order, waiting for each stage's ready before releasing the next. It also performs the same sequence automatically after system reset, and exposes busy, status and a completion counter to software.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequenced stages, legal range 1..8.
- `HOLD_DEFAULT`, 16: hold length in cycles loaded at reset, 16-bit.
- `TIMEOUT_CYCLES`, 1024: per-stage ready wait limit. Used only when the timeout macro is defined.

Ports:
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, read latency 0 (combinational from `address`).
- `stage_ready`  in  NUM_STAGES  per-stage "out of reset, operational" flags.
- `stage_rst`  out  NUM_STAGES  per-stage active-high reset, registered.
- `out_port`  out  1  legacy software-reset line; equals busy.

## Operation
Register map. A write is `chipselect && !write_n`.
- Address 0, CTRL:
  - Write: bit0=1 means start (ignored while busy); bit1 = hold level.
  - Read: bit0 busy, bit1 hold.
- Address 1, STATUS (read):
  - [2:0] state code: IDLE=0, ASSERT=1, RELEASE=2, DONE=3.
  - [6:4] current stage index.
  - [8] timeout sticky flag.
  - [11:9] index of the last stage that timed out.
  - [23:16] `stage_ready` snapshot, zero-extended.
  - Write with bit8=1 clears the timeout flag.
- Address 2, HOLD: [15:0] read/write hold length. A value of 0 is treated as 1.
- Address 3, COUNT: [15:0] completed sequences. Read-only, wraps at 0xFFFF→0.

FSM:
- **IDLE**: `stage_rst` is all 0. A start write moves to ASSERT and latches HOLD into the hold counter.
- **ASSERT**: `stage_rst` is all 1. The counter decrements each cycle. At terminal count:
  - If hold=0, go to RELEASE with index 0.
  - If hold=1, stay in ASSERT until hold is cleared, then go to RELEASE on the next cycle.
- **RELEASE(i)**: `stage_rst[i]` is cleared on entry, and stages above i stay asserted.
  - `stage_ready[i]` is sampled from the cycle after entry onward.
  - When it is sampled high: if i<NUM_STAGES-1, go to RELEASE(i+1); otherwise go to DONE.
- **DONE**: lasts one cycle. COUNT increments, then the FSM returns to IDLE.

Busy is 1 in any state other than IDLE.

## Timing
- Values during reset, and on the first cycle after it:
  - `stage_rst` all 1, `out_port`=1, state=ASSERT.
  - hold counter = HOLD_DEFAULT, HOLD reg = HOLD_DEFAULT.
  - COUNT=0, timeout flag=0, CTRL.hold=0, index=0.
- Power-on and reset mid-operation: reset aborts any sequence and restarts from ASSERT.
- Start write sampled at edge N:
  - `stage_rst` goes all 1 after edge N.
  - RELEASE(0) is entered after edge N+H, where H = latched hold (0 treated as 1).
- Release stride: stage i is released at cycle T. If `stage_ready[i]` is first high at cycle S ≥ T+1, stage i+1 is released at S+1.
  - Minimum stride is 2 cycles.
  - A ready that is already high at T does not count until T+1.
- Writes to HOLD during a sequence take effect from the next start.
- Start and hold written in the same cycle: the sequence starts with hold active.
- Start while busy is ignored. This includes a start written in the same cycle as DONE.
- Clearing hold outside ASSERT only updates the register.
- `stage_ready` deasserting after a stage has been released has no effect on the sequence.
- COUNT at 0xFFFF increments to 0x0000.

## Configuration
- `LOCKIN_RST_TIMEOUT_EN` defined:
  - RELEASE(i) counts cycles from entry.
  - After TIMEOUT_CYCLES cycles without ready, the block sets the timeout flag, records i in STATUS[11:9], and advances as if ready had been seen.
  - A flag-clear write in the same cycle as a new timeout leaves the flag set.
- Not defined:
  - No timeout counter is implemented; RELEASE waits indefinitely.
  - STATUS[11:8] reads 0 and the clear write is ignored.

## Test plan
- Reset, NUM_STAGES=4, all `stage_ready` tied 1:
  - `stage_rst` is 0xF for 16 cycles.
  - Then 0xE, 0xC, 0x8, 0x0 at a 2-cycle stride.
  - COUNT=1, busy drops.
- HOLD=5, start write:
  - `stage_rst`=0xF for exactly 5 cycles after the write edge.
  - Write a second start during RELEASE; it is ignored and COUNT increments by exactly 1.
- Start with hold=1: stays in ASSERT (STATUS[2:0]=1) for 100 cycles. Clearing hold gives RELEASE(0) on the next cycle.
- `stage_ready[1]` held 0 with the macro defined, TIMEOUT_CYCLES=1024:
  - Stage 2 is released 1025 cycles after stage 1.
  - STATUS[8]=1 and [11:9]=1.
  - Write 0x100 to STATUS; the flag clears.
- Assert `reset` while in RELEASE(2): `stage_rst` returns to 0xF and COUNT=0, then a full sequence reruns.
- Preload COUNT to 0xFFFF through 65535 sequences (or force it in the bench), run one more sequence: reads 0x0000.
